address_sequencer: RTL

- Produces the true-address-state (TAS) sequence that feeds the address generator during a march element.
- Owns the sequential side of addressing: initial value, stepping, direction, last-address detection and element completion.
- Sits between the march controller (start/step handshake) and the combinational address generator (tas_out to tas_in, admd_out to admd_in, updwn_out to updwn_in).

---
 rtl/address_sequencer_pkg.sv | 43 ++++
 rtl/address_sequencer_if.sv | 35 +++
 rtl/tas_updown_counter.sv | 34 +++
 rtl/address_sequencer.sv | 84 ++++++++
 4 files changed

// File: rtl/address_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : address_sequencer_pkg
// Brief    : Shared widths, address-mode codes, direction codes and FSM states
//            for the march address sequencer.
// Revision : 1.0
// ============================================================================
package address_sequencer_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int ADMD_WIDTH = 4;

    localparam logic [ADMD_WIDTH-1:0] ADMD_2I0 = 4'd0;
    localparam logic [ADMD_WIDTH-1:0] ADMD_2I1 = 4'd1;
    localparam logic [ADMD_WIDTH-1:0] ADMD_2I2 = 4'd2;
    localparam logic [ADMD_WIDTH-1:0] ADMD_2I3 = 4'd3;
    localparam logic [ADMD_WIDTH-1:0] ADMD_2I4 = 4'd4;
    localparam logic [ADMD_WIDTH-1:0] ADMD_2I5 = 4'd5;
    localparam logic [ADMD_WIDTH-1:0] ADMD_2I6 = 4'd6;
    localparam logic [ADMD_WIDTH-1:0] ADMD_2I7 = 4'd7;
    localparam logic [ADMD_WIDTH-1:0] ADMD_AC  = 4'd8;
    localparam logic [ADMD_WIDTH-1:0] ADMD_GC  = 4'd9;

    localparam logic ADDR_UP   = 1'b0;
    localparam logic ADDR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        ASEQ_IDLE = 2'd0,
        ASEQ_RUN  = 2'd1,
        ASEQ_DONE = 2'd2
    } aseq_state_t;

    function automatic logic admd_is_2i(input logic [ADMD_WIDTH-1:0] code);
        return (code <= ADMD_2I7);
    endfunction

    // Codes outside the defined set behave exactly like 2^0 addressing.
    function automatic logic [ADMD_WIDTH-1:0] admd_normalize(input logic [ADMD_WIDTH-1:0] code);
        return (code <= ADMD_GC) ? code : ADMD_2I0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/address_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : address_sequencer_if
// Brief    : Controller-to-sequencer handshake and sequencer-to-generator bus.
// Revision : 1.0
// ============================================================================
interface address_sequencer_if
    import address_sequencer_pkg::*;
#(
    parameter int TASW  = ADDR_WIDTH,
    parameter int ADMDW = ADMD_WIDTH
);
    logic             start_in;
    logic             step_in;
    logic [ADMDW-1:0] admd_in;
    logic             updwn_in;
    logic [TASW-1:0]  tas_out;
    logic [ADMDW-1:0] admd_out;
    logic             updwn_out;
    logic             valid_out;
    logic             last_out;
    logic             done_out;
    logic             busy_out;

    modport master (
        output start_in, step_in, admd_in, updwn_in,
        input  tas_out, admd_out, updwn_out, valid_out, last_out, done_out, busy_out
    );

    modport slave (
        input  start_in, step_in, admd_in, updwn_in,
        output tas_out, admd_out, updwn_out, valid_out, last_out, done_out, busy_out
    );
endinterface
`default_nettype wire

// File: rtl/tas_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tas_updown_counter
// Brief    : Loadable up/down TAS counter with final-address detection.
// Revision : 1.0
// ============================================================================
module tas_updown_counter #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic             en,
    input  wire logic             dir,
    input  wire logic [WIDTH-1:0] load_val,
    output logic      [WIDTH-1:0] cnt,
    output logic                  at_final
);
    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en) begin
            r_cnt <= dir ? (r_cnt - 1'b1) : (r_cnt + 1'b1);
        end
    end

    assign cnt      = r_cnt;
    assign at_final = dir ? (r_cnt == '0) : (r_cnt == {WIDTH{1'b1}});
endmodule
`default_nettype wire

// File: rtl/address_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : address_sequencer
// Brief    : March-element TAS sequencer: start/step FSM driving the counter.
// Revision : 1.0
// ============================================================================
module address_sequencer
    import address_sequencer_pkg::*;
#(
    parameter int TASW  = ADDR_WIDTH,
    parameter int ADMDW = ADMD_WIDTH
) (
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    address_sequencer_if.slave bus
);
    aseq_state_t      r_state;
    aseq_state_t      w_state_next;
    logic [ADMDW-1:0] r_admd;
    logic             r_updwn;
    logic             r_cnt_down;

    logic [ADMDW-1:0] w_admd_norm;
    logic             w_start_down;
    logic             w_cnt_en;
    logic             w_at_final;
    logic [TASW-1:0]  w_tas;

    // AC/GC always count up: the generator realises their direction via the MSB.
    assign w_admd_norm  = admd_normalize(bus.admd_in);
    assign w_start_down = admd_is_2i(w_admd_norm) && (bus.updwn_in == ADDR_DOWN);
    assign w_cnt_en     = (r_state == ASEQ_RUN) && bus.step_in && !bus.start_in && !w_at_final;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ASEQ_IDLE;
            r_admd     <= ADMD_2I0;
            r_updwn    <= ADDR_UP;
            r_cnt_down <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (bus.start_in) begin
                r_admd     <= w_admd_norm;
                r_updwn    <= bus.updwn_in;
                r_cnt_down <= w_start_down;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.start_in) begin
            w_state_next = ASEQ_RUN;
        end else begin
            case (r_state)
                ASEQ_RUN:  if (bus.step_in && w_at_final) w_state_next = ASEQ_DONE;
                ASEQ_DONE: w_state_next = ASEQ_IDLE;
                default:   w_state_next = ASEQ_IDLE;
            endcase
        end
    end

    tas_updown_counter #(
        .WIDTH (TASW)
    ) u_counter (
        .clk      (clk_in),
        .rst      (rst_in),
        .load     (bus.start_in),
        .en       (w_cnt_en),
        .dir      (r_cnt_down),
        .load_val (w_start_down ? {TASW{1'b1}} : {TASW{1'b0}}),
        .cnt      (w_tas),
        .at_final (w_at_final)
    );

    assign bus.tas_out   = w_tas;
    assign bus.admd_out  = r_admd;
    assign bus.updwn_out = r_updwn;
    assign bus.valid_out = (r_state == ASEQ_RUN);
    assign bus.busy_out  = (r_state == ASEQ_RUN);
    assign bus.done_out  = (r_state == ASEQ_DONE);
    assign bus.last_out  = (r_state == ASEQ_RUN) && w_at_final;
endmodule
`default_nettype wire
